// File: rtl/alu_issue_stage.sv
// Command FIFO, execute register and result register wrapped around an external combinational ALU.
// Optional op_count handshake counter is built when ALU_ISSUE_CNT_EN is defined.
module alu_issue_stage #(
    parameter int RAM_WIDTH = 32,
    parameter int WIDTH     = 2,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_opcode,
    input  logic [RAM_WIDTH-1:0] cmd_op1,
    input  logic [RAM_WIDTH-1:0] cmd_op2,
    output logic [WIDTH-1:0]     alu_opcode,
    output logic [RAM_WIDTH-1:0] alu_op1,
    output logic [RAM_WIDTH-1:0] alu_op2,
    input  logic [RAM_WIDTH-1:0] alu_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RAM_WIDTH-1:0] res_data,
    output logic [WIDTH-1:0]     res_opcode,
    output logic                 busy
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [15:0]          op_count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.

    logic [WIDTH-1:0]     fifo_opc [DEPTH];
    logic [RAM_WIDTH-1:0] fifo_op1 [DEPTH];
    logic [RAM_WIDTH-1:0] fifo_op2 [DEPTH];

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [WIDTH-1:0]     ex_opc_q, ex_opc_d;
    logic [RAM_WIDTH-1:0] ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
    logic                 res_valid_q, res_valid_d;
    logic [RAM_WIDTH-1:0] res_data_q, res_data_d;
    logic [WIDTH-1:0]     res_opc_q, res_opc_d;

    logic push, fifo_ne, res_adv, ex_load;

    // Ready depends on registered occupancy only, so a pop never raises it in the same cycle.
    assign cmd_ready = (count_q < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign fifo_ne   = (count_q != '0);
    assign res_adv   = ex_valid_q && (!res_valid_q || res_ready);
    assign ex_load   = fifo_ne && (!ex_valid_q || res_adv);

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(ex_load);
        count_d     = count_q + CW'(push) - CW'(ex_load);
        ex_valid_d  = ex_valid_q;
        ex_opc_d    = ex_opc_q;
        ex_op1_d    = ex_op1_q;
        ex_op2_d    = ex_op2_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_opc_d   = res_opc_q;

        if (ex_load) begin
            ex_valid_d = 1'b1;
            ex_opc_d   = fifo_opc[rd_ptr_q];
            ex_op1_d   = fifo_op1[rd_ptr_q];
            ex_op2_d   = fifo_op2[rd_ptr_q];
        end else if (res_adv) begin
            ex_valid_d = 1'b0;
        end

        if (res_adv) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_result;
            res_opc_d   = ex_opc_q;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_opc[wr_ptr_q] <= cmd_opcode;
            fifo_op1[wr_ptr_q] <= cmd_op1;
            fifo_op2[wr_ptr_q] <= cmd_op2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ex_valid_q  <= 1'b0;
            ex_opc_q    <= '0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_opc_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ex_valid_q  <= ex_valid_d;
            ex_opc_q    <= ex_opc_d;
            ex_op1_q    <= ex_op1_d;
            ex_op2_q    <= ex_op2_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_opc_q   <= res_opc_d;
        end
    end

    // Operand ports keep their last values while the execute register is empty.
    assign alu_opcode = ex_opc_q;
    assign alu_op1    = ex_op1_q;
    assign alu_op2    = ex_op2_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_opcode = res_opc_q;
    assign busy       = fifo_ne || ex_valid_q || res_valid_q;

`ifdef ALU_ISSUE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 16'(res_valid_q && res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, table-driven stream, scoreboard on result handshakes.
// Build with ALU_ISSUE_CNT_EN defined to also exercise op_count.
module tb_alu_issue_stage;

    localparam int RW = 32;
    localparam int OW = 2;
    localparam int W  = RW + OW;

    logic          clk, rst_n;
    logic          cmd_valid, cmd_ready;
    logic [OW-1:0] cmd_opcode, alu_opcode, res_opcode;
    logic [RW-1:0] cmd_op1, cmd_op2, alu_op1, alu_op2, alu_result, res_data;
    logic          res_valid, res_ready, busy;
`ifdef ALU_ISSUE_CNT_EN
    logic [15:0]   op_count;
`endif

    alu_issue_stage #(.RAM_WIDTH(RW), .WIDTH(OW), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_op1    (cmd_op1),
        .cmd_op2    (cmd_op2),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_opcode (res_opcode),
        .busy       (busy)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    // Combinational ALU the stage drives
    always_comb begin
        case (alu_opcode)
            2'd0:    alu_result = alu_op1 + alu_op2;
            2'd1:    alu_result = alu_op1 - alu_op2;
            2'd2:    alu_result = alu_op1 * alu_op2;
            default: alu_result = ~(alu_op1 & alu_op2);
        endcase
    end

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compared;
    int mismatched;
    int cyc;
    logic [W-1:0]  exp_q[$];
    int            pop_cyc[$];
    logic [RW-1:0] cur_exp;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: handshakes are decided by the values stable at the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: got 0x%0h with empty expected queue", {res_opcode, res_data});
                end else begin
                    check("result", {30'd0, res_opcode, res_data}, {30'd0, exp_q.pop_front()});
                    pop_cyc.push_back(cyc);
                end
            end
            if (cmd_valid && cmd_ready) exp_q.push_back({cmd_opcode, cur_exp});
        end
    end

    // Driver tasks
    task automatic send(input logic [OW-1:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b,
                        input logic [RW-1:0] e);
        int n;
        n = 0;
        cmd_opcode = op;
        cmd_op1    = a;
        cmd_op2    = b;
        cur_exp    = e;
        cmd_valid  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        if (!cmd_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: cmd_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        check("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    typedef struct {
        logic [OW-1:0] op;
        logic [RW-1:0] a;
        logic [RW-1:0] b;
        logic [RW-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int k;
        int gaps;
        logic acc;

        vecs[0] = '{2'd1, 32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[1] = '{2'd2, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000};
        vecs[2] = '{2'd3, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_FFFF};
        vecs[3] = '{2'd0, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
        vecs[4] = '{2'd2, 32'd3,          32'd7,          32'd21};
        vecs[5] = '{2'd1, 32'd0,          32'd1,          32'hFFFF_FFFF};
        vecs[6] = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[7] = '{2'd0, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678};

        compared = 0; mismatched = 0; cyc = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_op1 = '0; cmd_op2 = '0;
        res_ready = 1'b0; cur_exp = '0;

        #12;
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_outputs",   {30'd0, alu_opcode, alu_op1 | alu_op2 | res_data}, 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Latency: accept at E0, result visible after E2
        @(posedge clk);
        #1;
        cmd_opcode = 2'd0; cmd_op1 = 32'd5; cmd_op2 = 32'd3; cur_exp = 32'd8;
        cmd_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("lat_after_e0", {63'd0, res_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_after_e1", {63'd0, res_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_after_e2", {63'd0, res_valid}, 64'd1);
        check("lat_data",     {32'd0, res_data},  64'd8);
        check("lat_opcode",   {62'd0, res_opcode}, 64'd0);
        wait_idle();

        // Back-to-back stream from the vector table
        @(posedge clk);
        #1;
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        wait_idle();
        gaps = 0;
        for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] - pop_cyc[i-1] != 1) gaps++;
        check("stream_count", 64'(pop_cyc.size()), 64'd8);
        check("stream_gaps",  64'(gaps), 64'd0);

        // Backpressure: offer 6 commands with res_ready low
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        k = 0;
        cmd_opcode = 2'd0; cmd_op1 = 32'd0; cmd_op2 = 32'd100; cur_exp = 32'd100; cmd_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                cmd_op1 = RW'(k);
                cur_exp = RW'(k + 100);
            end
        end
        @(negedge clk);
        check("bp_accepted",  64'(k), 64'd4);
        check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("bp_res_valid", {63'd0, res_valid}, 64'd1);
        check("bp_res_hold",  {32'd0, res_data},  64'd100);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_no_early_ready", {63'd0, cmd_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_after_pop", {63'd0, cmd_ready}, 64'd1);
        wait_idle();
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three commands in flight
        @(posedge clk);
        #1 res_ready = 1'b0;
        send(2'd0, 32'd7, 32'd7, 32'd14);
        send(2'd1, 32'd9, 32'd2, 32'd7);
        send(2'd2, 32'd4, 32'd4, 32'd16);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("mid_rst_busy",      {63'd0, busy},      64'd0);
        check("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("mid_rst_outputs",   {30'd0, res_opcode, res_data | alu_op1 | alu_op2}, 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        send(2'd0, 32'd1, 32'd1, 32'd2);
        wait_idle();
        check("post_rst_empty", 64'(exp_q.size()), 64'd0);

        // Idle hold of operand ports
        @(posedge clk);
        #1;
        send(2'd3, 32'h1234_5678, 32'h0F0F_0F0F, 32'hFDFB_F9F7);
        wait_idle();
        repeat (3) @(negedge clk);
        check("idle_op1",  {32'd0, alu_op1}, 64'h1234_5678);
        check("idle_op2",  {32'd0, alu_op2}, 64'h0F0F_0F0F);
        check("idle_opc",  {62'd0, alu_opcode}, 64'd3);
        check("idle_busy", {63'd0, busy}, 64'd0);

`ifdef ALU_ISSUE_CNT_EN
        // Handshake counter: reset value, stall, wrap
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1 check("cnt_reset", {48'd0, op_count}, 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        send(2'd0, 32'd2, 32'd2, 32'd4);
        repeat (4) @(negedge clk);
        check("cnt_stall_valid", {63'd0, res_valid}, 64'd1);
        check("cnt_stall",       {48'd0, op_count}, 64'd0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle();
        check("cnt_one", {48'd0, op_count}, 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 65536; i++) send(2'd0, RW'(i), 32'd1, RW'(i + 1));
        wait_idle();
        check("cnt_wrap", {48'd0, op_count}, 64'd1);
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command-queue and pipeline-register stage wrapped around the combinational ALU. It accepts ALU commands (opcode, op1, op2) over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU operand ports from an execute register and captures the ALU result into an output register with its own valid/ready handshake. It sits between the command source (sequencer or memory read path) and the ALU's consumer, and it isolates both sides from the ALU's combinational path.

## Interface
- RAM_WIDTH, 32, operand and result width; must match the ALU's RAM_WIDTH.
- WIDTH, 2, opcode width; must match the ALU's WIDTH.
- DEPTH, 2, command FIFO entries; a power of two, at least 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  the stage can accept a command.
- cmd_opcode  in  WIDTH  0=ADD, 1=SUB, 2=MUL, 3=NAND.
- cmd_op1, cmd_op2  in  RAM_WIDTH  operands.
- alu_opcode  out  WIDTH  to ALU opcode.
- alu_op1, alu_op2  out  RAM_WIDTH  to ALU operands.
- alu_result  in  RAM_WIDTH  from ALU result; combinational function of alu_* outputs.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_data  out  RAM_WIDTH  captured result.
- res_opcode  out  WIDTH  opcode that produced res_data.
- busy  out  1  FIFO non-empty, or ex_valid, or res_valid.

## Operation
- Three storage levels:
  - FIFO (DEPTH entries).
  - Execute register (ex_valid, opcode, op1, op2). It drives alu_* directly.
  - Result register (res_valid, res_data, res_opcode).
- Push: cmd_valid && cmd_ready at a clock edge writes the FIFO at wr_ptr. wr_ptr increments mod DEPTH.
- cmd_ready = (count < DEPTH), derived from registered state only. There is no combinational path from res_ready or cmd_valid. When full, cmd_ready stays 0 even if a pop occurs in the same cycle.
- Result register advance: res_adv = ex_valid && (!res_valid || res_ready).
  - On res_adv: res_data <= alu_result, res_opcode <= ex opcode, res_valid <= 1.
  - If res_valid && res_ready && !res_adv: res_valid <= 0.
- Execute register load: ex_load = fifo non-empty && (!ex_valid || res_adv).
  - On ex_load: load the FIFO head, ex_valid <= 1, rd_ptr increments mod DEPTH.
  - If res_adv && !ex_load: ex_valid <= 0.
- When ex_valid = 0, alu_* hold their last values; they do not return to zero.
- Ordering: results leave in strict command order. No command is dropped or duplicated.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged.
- Push into an empty FIFO: there is no bypass; the entry reaches the execute register on the next edge.
- While res_valid && !res_ready, res_data and res_opcode are held stable.
- Arithmetic belongs to the ALU; this stage forwards alu_result unmodified (truncated to RAM_WIDTH by the ALU).
- Reset, asserted at any time including mid-operation:
  - Pointers, count, ex_valid and res_valid clear immediately; in-flight commands are discarded.
  - All outputs go to 0, except cmd_ready, which is 1 (the FIFO is empty).

## Timing
- Latency: a command accepted at edge E0 enters the execute register at E1. Its result is captured at E2, so res_valid is high in the cycle after E2. Minimum latency is 2 clocks.
- Throughput: one command per clock with res_ready held high and cmd_valid held high.
- Capacity under full backpressure: DEPTH + 2 commands in flight (4 at DEPTH=2).
- After backpressure releases, the first result handshake frees the result register in the same edge. cmd_ready rises one cycle after the FIFO pop.
- The ALU combinational delay and the result-register setup must fit within one clock.

## Configuration
- ALU_ISSUE_CNT_EN defined:
  - Adds output op_count[15:0].
  - op_count increments on each res_valid && res_ready edge and wraps from 0xFFFF to 0x0000.
  - op_count resets to 0.
- ALU_ISSUE_CNT_EN undefined: the op_count port and its counter logic are absent. All other behaviour is identical.

## Test plan
- ADD with op1=5, op2=3, res_ready=1 -> res_valid rises exactly 2 edges after accept; res_data=0x00000008, res_opcode=0.
- Back-to-back stream, one per clock:
  - SUB 3,5 -> res_data=0xFFFFFFFE.
  - MUL 0x00010000,0x00010000 -> res_data=0x00000000.
  - NAND 0xFFFF0000,0x0F0F0F0F -> res_data=0xF0F0FFFF.
  - Results appear on consecutive cycles, in order.
- Backpressure at DEPTH=2: hold res_ready=0 and offer 6 commands.
  - Exactly 4 are accepted, then cmd_ready=0.
  - res_data stays stable.
  - Raising res_ready drains all 4 in order, and cmd_ready reasserts after the first pop.
- Reset mid-operation: assert rst_n=0 with 3 commands in flight.
  - res_valid=0, busy=0 and cmd_ready=1 immediately.
  - After release, a new ADD 1,1 yields 2 with no stale results.
- Idle hold: after the last command drains, alu_op1, alu_op2 and alu_opcode keep their last values, and busy=0.
- With ALU_ISSUE_CNT_EN: 65537 completed handshakes -> op_count=1. A stall cycle (res_valid=1, res_ready=0) does not increment op_count.
